hex_display_scheduler: RTL and testbench
========================================

// Module: hex_display_scheduler
// PURPOSE
//  Shares the six DE1-SoC seven-segment displays (HEX0..HEX5) among NUM_SRC
//  requesters (store item lookup, price, totals, ...). Uses round-robin arbitration.
//  A granted source's 6-digit message is snapshotted and shown for a fixed dwell time.
//  The source then gets a done pulse, and the displays blank for a short gap.
//  Sits between the store logic and the HEX pins; replaces direct seg7-to-HEX wiring.
// PARAMETERS
//  NUM_SRC       4           number of requesters (2..8)
//  DWELL_CYCLES  50_000_000  clk cycles a granted message is shown (>=1; 1 s at 50 MHz)
//  GAP_CYCLES    5_000_000   clk cycles of blank display between messages (>=1)
// PORTS
//  clk         in   1          system clock (CLOCK_50)
//  reset       in   1          asynchronous, active-high reset
//  req         in   NUM_SRC    per-source display request, level; held until done
//  digits      in   NUM_SRC*24 src i message = digits[24*i +: 24]; nibble k -> HEXk
//  blank_mask  in   NUM_SRC*6  src i = blank_mask[6*i +: 6]; bit k=1 blanks HEXk
//  hold        in   1          freezes the dwell counter while in SHOW (e.g. KEY pressed)
//  grant       out  NUM_SRC    one-hot owner of the displays; 0 when none
//  done        out  NUM_SRC    one-cycle pulse to source whose dwell completed
//  busy        out  1          1 in SHOW or GAP
//  HEX0..HEX5  out  7 each     active-low segments {g,f,e,d,c,b,a}
// BEHAVIOUR
//  Reset (async): state=IDLE; grant=0, done=0, busy=0; HEXn=7'h7F (all off);
//   rr_ptr=NUM_SRC-1, so source 0 wins first; counters=0; digit/mask regs=0/all-blank.
//  FSM states: IDLE, SHOW, GAP. All outputs are registered or decoded from registers.
//  IDLE: if |req at an edge, the round-robin winner is chosen at that edge.
//   Search starts at rr_ptr+1 mod NUM_SRC.
//   Same edge: grant<=onehot(w), rr_ptr<=w, latch digits/blank_mask of w.
//   Same edge: cnt<=DWELL_CYCLES-1, state<=SHOW. Latency req->grant/HEX = 1 clk.
//  SHOW: HEX shows the latched snapshot; later changes to digits are ignored.
//   Nibbles >9 display as A-F via seg7.
//   If req[w]==0 at an edge -> GAP: no done pulse, grant<=0, cnt<=GAP_CYCLES-1.
//    Request withdrawal takes priority over dwell expiry.
//   Else if hold==1: cnt holds.
//   Else if cnt==0 -> GAP: done[w]<=1 for one cycle, grant<=0, cnt<=GAP_CYCLES-1.
//   Else cnt<=cnt-1. Grant lasts exactly DWELL_CYCLES unheld cycles.
//  GAP: HEX all 7'h7F; hold ignored; cnt==0 -> IDLE, else decrement.
//   A new grant occurs no earlier than 1 clk after entering IDLE.
//  Requests arriving during SHOW/GAP wait (no queue beyond the req levels).
//   A source still requesting after done is re-eligible but ranks lowest.
//  Unused upper bits of cnt must not wrap: cnt width = clog2 of max(DWELL,GAP).
//  Reset asserted mid-SHOW/GAP: immediate return to reset values, no done pulse.
// STRUCTURE
//  Package hex_sched_pkg: state_t enum {IDLE,SHOW,GAP}; SEG_BLANK=7'h7F;
//   DIGITS=6; NIBBLE_W=4.
//  Sub-module: six instances of the existing seg7 decoder (nibble -> 7-bit).
//   Each is followed by a blank mux (mask bit or state!=SHOW -> SEG_BLANK).
//  Round-robin picker is a local function/always_comb, not a separate module.
// TESTING  (DWELL_CYCLES=4, GAP_CYCLES=2, NUM_SRC=4 unless stated)
//  1 reset high, req=4'hF -> grant=0, done=0, busy=0, all HEX=7'h7F throughout.
//  2 req=4'b0100, digits src2=24'h012345, mask=0 -> grant=4'b0100 1 clk later.
//    HEX0=7'b0010010 ("5"), HEX5=7'b1000000 ("0").
//    grant high 4 clks, then done[2] 1 clk, HEX blank 2 clks, then IDLE.
//  3 req=4'b1011 held, sources drop+reraise req on done ->
//    grant order 0001,0010,1000,0001; each followed by matching done pulse.
//  4 src1 granted, req[1] dropped after 2 clks ->
//    grant 0 next clk, no done pulse, HEX blank for GAP, then IDLE.
//  5 src0 granted, hold=1 for 10 clks mid-dwell ->
//    grant lasts 14 clks total, single done[0] pulse at end.
//  6 async reset asserted mid-SHOW between clk edges ->
//    grant/HEX reset immediately; after release, src0 wins first again.

Source files
------------

// File: rtl/hex_sched_pkg.sv
// rtl/hex_sched_pkg.sv - shared types and constants for the HEX display scheduler
package hex_sched_pkg;
    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam int         DIGITS    = 6;
    localparam int         NIBBLE_W  = 4;
endpackage

// File: rtl/seg7.sv
// rtl/seg7.sv - hex nibble to active-low {g,f,e,d,c,b,a} segment decoder
module seg7 (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    always_comb begin
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    end
endmodule

// File: rtl/hex_display_scheduler.sv
// rtl/hex_display_scheduler.sv - round-robin sharing of HEX0..HEX5 among requesters
module hex_display_scheduler
    import hex_sched_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int GAP_CYCLES   = 5_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        req,
    input  logic [NUM_SRC*24-1:0]     digits,
    input  logic [NUM_SRC*DIGITS-1:0] blank_mask,
    input  logic                      hold,
    output logic [NUM_SRC-1:0]        grant,
    output logic [NUM_SRC-1:0]        done,
    output logic                      busy,
    output logic [6:0]                HEX0,
    output logic [6:0]                HEX1,
    output logic [6:0]                HEX2,
    output logic [6:0]                HEX3,
    output logic [6:0]                HEX4,
    output logic [6:0]                HEX5
);
    localparam int MAX_CNT = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int PTR_W   = $clog2(NUM_SRC);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

    state_t                      state;
    logic [PTR_W-1:0]            rr_ptr;
    logic [CNT_W-1:0]            cnt;
    logic [DIGITS*NIBBLE_W-1:0]  snap_digits;
    logic [DIGITS-1:0]           snap_mask;

    logic                        pick_valid;
    logic [PTR_W-1:0]            pick_idx;
    logic [PTR_W-1:0]            cand;

    // Scan from farthest to nearest so the closest requester after rr_ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = rr_ptr;
        cand       = '0;
        for (int i = NUM_SRC; i >= 1; i--) begin
            cand = PTR_W'((int'(rr_ptr) + i) % NUM_SRC);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            done        <= '0;
            busy        <= 1'b0;
            rr_ptr      <= PTR_W'(NUM_SRC - 1);
            cnt         <= '0;
            snap_digits <= '0;
            snap_mask   <= '1;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant       <= NUM_SRC'(1) << pick_idx;
                        rr_ptr      <= pick_idx;
                        snap_digits <= digits[24*pick_idx +: 24];
                        snap_mask   <= blank_mask[DIGITS*pick_idx +: DIGITS];
                        cnt         <= DWELL_LOAD;
                        busy        <= 1'b1;
                        state       <= SHOW;
                    end
                end
                SHOW: begin
                    if (!req[rr_ptr]) begin
                        grant <= '0;
                        cnt   <= GAP_LOAD;
                        state <= GAP;
                    end else if (hold) begin
                        cnt <= cnt;
                    end else if (cnt == '0) begin
                        done  <= NUM_SRC'(1) << rr_ptr;
                        grant <= '0;
                        cnt   <= GAP_LOAD;
                        state <= GAP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [DIGITS-1:0][6:0] raw_seg;
    logic [DIGITS-1:0][6:0] hex_seg;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        seg7 u_seg7 (
            .nibble (snap_digits[NIBBLE_W*k +: NIBBLE_W]),
            .seg    (raw_seg[k])
        );
        assign hex_seg[k] = (snap_mask[k] || state != SHOW) ? SEG_BLANK : raw_seg[k];
    end

    assign HEX0 = hex_seg[0];
    assign HEX1 = hex_seg[1];
    assign HEX2 = hex_seg[2];
    assign HEX3 = hex_seg[3];
    assign HEX4 = hex_seg[4];
    assign HEX5 = hex_seg[5];
endmodule

// File: tb/tb_hex_display_scheduler.sv
// tb/tb_hex_display_scheduler.sv - directed self-checking bench for hex_display_scheduler
module tb_hex_display_scheduler;
    localparam int NUM_SRC = 4;
    localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [95:0] digits;
    logic [23:0] blank_mask;
    logic        hold;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [41:0] hex_all;

    assign hex_all = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    hex_display_scheduler #(
        .NUM_SRC      (NUM_SRC),
        .DWELL_CYCLES (4),
        .GAP_CYCLES   (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .digits     (digits),
        .blank_mask (blank_mask),
        .hold       (hold),
        .grant      (grant),
        .done       (done),
        .busy       (busy),
        .HEX0       (HEX0),
        .HEX1       (HEX1),
        .HEX2       (HEX2),
        .HEX3       (HEX3),
        .HEX4       (HEX4),
        .HEX5       (HEX5)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_reset();
        req = '0;
        hold = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", 64'(busy), 64'd0);
    endtask

    typedef struct {
        int          src;
        logic [23:0] dig;
        logic [5:0]  mask;
        logic [41:0] hex;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{2, 24'h012345, 6'b000000, {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12}};
        vecs[1] = '{1, 24'h6789AB, 6'b000000, {7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03}};
        vecs[2] = '{3, 24'hCDEF00, 6'b000011, {7'h46, 7'h21, 7'h06, 7'h0E, 7'h7F, 7'h7F}};
        vecs[3] = '{0, 24'h888888, 6'b101010, {7'h7F, 7'h00, 7'h7F, 7'h00, 7'h7F, 7'h00}};

        // Reset held with all sources requesting: everything stays quiet.
        reset = 1'b1;
        req = 4'hF;
        hold = 1'b0;
        digits = {4{24'h123456}};
        blank_mask = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_grant", 64'(grant), 64'd0);
            check("rst_done_busy", 64'({done, busy}), 64'd0);
            check("rst_hex", 64'(hex_all), 64'(ALL_BLANK));
        end
        req = '0;
        reset = 1'b0;
        @(negedge clk);

        // Full dwell of source 2.
        digits[48 +: 24] = 24'h012345;
        req = 4'b0100;
        @(negedge clk);
        check("t2_grant", 64'(grant), 64'h4);
        check("t2_hex0", 64'(HEX0), 64'h12);
        check("t2_hex5", 64'(HEX5), 64'h40);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check("t2_grant_hold", 64'({grant, done}), 64'h40);
        end
        @(negedge clk);
        check("t2_done", 64'({grant, done}), 64'h04);
        check("t2_gap_hex", 64'(hex_all), 64'(ALL_BLANK));
        check("t2_gap_busy", 64'(busy), 64'd1);
        req = '0;
        @(negedge clk);
        check("t2_done_once", 64'(done), 64'd0);
        check("t2_gap_hex2", 64'(hex_all), 64'(ALL_BLANK));
        @(negedge clk);
        check("t2_idle", 64'(busy), 64'd0);

        // Table: decode, masking and snapshot independence.
        for (int v = 0; v < 4; v++) begin
            digits = '0;
            blank_mask = '0;
            digits[24*vecs[v].src +: 24] = vecs[v].dig;
            blank_mask[6*vecs[v].src +: 6] = vecs[v].mask;
            req = 4'(1 << vecs[v].src);
            @(negedge clk);
            check($sformatf("vec%0d_grant", v), 64'(grant), 64'(1 << vecs[v].src));
            check($sformatf("vec%0d_hex", v), 64'(hex_all), 64'(vecs[v].hex));
            digits = ~digits;
            blank_mask = ~blank_mask;
            @(negedge clk);
            check($sformatf("vec%0d_snapshot", v), 64'(hex_all), 64'(vecs[v].hex));
            req = '0;
            @(negedge clk);
            check($sformatf("vec%0d_withdraw", v), 64'({grant, done}), 64'h0);
            wait_idle();
        end

        // Round-robin order with sources dropping and re-raising on done.
        do_reset();
        begin
            logic [3:0] order [4];
            logic [3:0] dropped;
            int n;
            order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b1000; order[3] = 4'b0001;
            req = 4'b1011;
            for (int g = 0; g < 4; g++) begin
                n = 0;
                do begin @(negedge clk); n++; end while (grant == '0 && n < 20);
                check($sformatf("rr_grant%0d", g), 64'(grant), 64'(order[g]));
                n = 0;
                do begin @(negedge clk); n++; end while (done == '0 && n < 20);
                check($sformatf("rr_done%0d", g), 64'(done), 64'(order[g]));
                dropped = done;
                req = req & ~dropped;
                @(negedge clk);
                req = req | dropped;
            end
            req = '0;
            wait_idle();
        end

        // Withdrawal after two cycles: no done, blank gap, back to idle.
        do_reset();
        req = 4'b0010;
        @(negedge clk);
        check("wd_grant", 64'(grant), 64'h2);
        @(negedge clk);
        req = '0;
        @(negedge clk);
        check("wd_drop", 64'({grant, done, busy}), 64'h01);
        check("wd_hex", 64'(hex_all), 64'(ALL_BLANK));
        @(negedge clk);
        check("wd_nodone", 64'({done, busy}), 64'h01);
        @(negedge clk);
        check("wd_idle", 64'(busy), 64'd0);

        // Hold for 10 cycles mid-dwell stretches the grant to 14 cycles.
        do_reset();
        begin
            int gcnt, dcnt;
            gcnt = 0;
            dcnt = 0;
            req = 4'b0001;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (grant == 4'b0001) gcnt++;
                if (done == 4'b0001) begin dcnt++; req = '0; end
                else if (done != '0) dcnt += 100;
                if (c == 1) hold = 1'b1;
                if (c == 11) hold = 1'b0;
            end
            check("hold_grant_cycles", 64'(gcnt), 64'd14);
            check("hold_done_pulses", 64'(dcnt), 64'd1);
        end

        // Async reset mid-show, then source 0 wins first again.
        do_reset();
        req = 4'b0110;
        @(posedge clk);
        #1;
        check("ar_pre_grant", 64'(grant), 64'h2);
        req = 4'hF;
        #2;
        reset = 1'b1;
        #1;
        check("ar_grant", 64'({grant, done, busy}), 64'h0);
        check("ar_hex", 64'(hex_all), 64'(ALL_BLANK));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("ar_src0_first", 64'(grant), 64'h1);
        req = '0;
        wait_idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
